sw_gates_debounced: RTL and testbench
=====================================

// Module: sw_gates_debounced
// PURPOSE
//   Parametrised sequential successor to the two-switch combinational gates block.
//   Takes N_SW raw board switches and synchronises each bit (2-FF). Debounces each
//   bit with a per-bit stability counter.
//   Drives registered AND/OR/XOR reductions of the clean switch vector, plus one-cycle
//   rise/fall pulses per switch. Sits between board switch pins and LED/logic consumers.
// PARAMETERS
//   N_SW            2        number of switch inputs (>=2)
//   DEBOUNCE_CYCLES 1000000  cycles a synchronised input must hold before acceptance (>=2; 10 ms @100 MHz)
//   CNT_W           $clog2(DEBOUNCE_CYCLES)  counter width (derived, not overridden)
// PORTS
//   clk       in   1     system clock, all logic on rising edge
//   rst_n     in   1     asynchronous, active-low reset
//   SW        in   N_SW  raw switch inputs, asynchronous to clk
//   sw_clean  out  N_SW  debounced switch state
//   sw_rise   out  N_SW  1-cycle pulse: sw_clean bit went 0->1
//   sw_fall   out  N_SW  1-cycle pulse: sw_clean bit went 1->0
//   y_and     out  1     registered &sw_clean
//   y_or      out  1     registered |sw_clean
//   y_xor     out  1     registered ^sw_clean
// BEHAVIOUR
//   Reset (rst_n=0, async): sync FFs, counters, sw_clean, sw_rise, sw_fall, y_and, y_or, y_xor all 0.
//   Per bit i: s_i = SW[i] after 2 FFs. Counter cnt_i is saturating-free; cnt_i < DEBOUNCE_CYCLES always.
//     s_i == sw_clean[i]                    -> cnt_i <= 0
//     s_i != clean, cnt_i <  DEBOUNCE_CYCLES-1 -> cnt_i <= cnt_i+1
//     s_i != clean, cnt_i == DEBOUNCE_CYCLES-1 -> sw_clean[i] <= s_i, cnt_i <= 0
//   Any mismatch break (glitch) restarts the count from 0; partial counts never accumulate.
//   Latency: SW edge -> sw_clean change = 2 (sync) + DEBOUNCE_CYCLES cycles, for an input held stable.
//   sw_rise/sw_fall and y_* are registered from sw_clean: they update exactly 1 cycle after sw_clean.
//     sw_rise[i] = clean_q[i] & ~clean_d1[i]; this fires for exactly 1 cycle per accepted edge.
//   Bits are independent. Simultaneous acceptance on several bits gives pulses in the same cycle.
//     The reductions then reflect the full new vector in one step, with no intermediate value.
//   A toggle faster than DEBOUNCE_CYCLES is never seen on the outputs.
//   Reset mid-count discards all progress. After release, a full debounce interval is required.
//   After release, an input held at 1 from reset gives sw_rise after 2+DEBOUNCE_CYCLES+1 cycles.
// CONFIGURATION
//   GATES_INVERT_EN defined:
//     adds outputs y_nand, y_nor, y_xnor (1 bit each), which are ~y_and, ~y_or, ~y_xor.
//     These are registered in the same cycle as y_*.
//     Reset value: 1 each, i.e. the inverse of the reset state.
//   GATES_INVERT_EN undefined: these ports and registers do not exist. All other behaviour is identical.
// STRUCTURE
//   Package gates_pkg: DEBOUNCE_DEFAULT (1000000), SYNC_STAGES (2), function cnt_width(n).
//   Sub-module sw_debounce (one bit: sync + counter + clean FF).
//     Instantiated N_SW times in a generate loop.
//   Top: edge-detect registers, reduction registers, GATES_INVERT_EN block.
// TESTING (bench uses N_SW=2, DEBOUNCE_CYCLES=4, 10 ns clk)
//   1. Reset with SW=2'b11 -> all outputs 0 during reset and on the first post-reset edge.
//   2. SW=2'b01 held stable -> sw_clean=01 at 6 cycles after change.
//      At cycle 7: y_or=1, y_xor=1, y_and=0, sw_rise=01 for one cycle.
//   3. SW[1] high 3 cycles then low (glitch) -> sw_clean, y_*, pulses unchanged.
//   4. SW 00->11 in one cycle -> sw_rise=11 in a single cycle; y_and=1, y_xor=0, y_or=1.
//      y_xor never shows 1 in between.
//   5. SW 0->1 on bit 0, then rst_n=0 at count 2 for 1 cycle -> outputs 0 immediately.
//      sw_clean[0] rises 6 cycles after rst_n release.
//   6. GATES_INVERT_EN defined, repeat test 4 -> y_nand=0, y_nor=0, y_xnor=1.
//      Reset value of the three outputs is 1.

Source files
------------

// File: rtl/gates_pkg.sv
// Shared constants and helpers for the debounced switch-gates block.
// Configuration macro used by the top: GATES_INVERT_EN.
package gates_pkg;

  // 10 ms at 100 MHz
  localparam int DEBOUNCE_DEFAULT = 1000000;
  // Synchroniser depth for raw board switches
  localparam int SYNC_STAGES = 2;

  // Width of a counter that only ever holds 0 .. n-1 (never less than 1 bit)
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: 2-FF synchroniser, stability counter and accepted (clean) state.
// The clean bit only moves after the synchronised input has disagreed with it for
// DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count from zero.
module sw_debounce
  import gates_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic clean
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Bring the asynchronous switch into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw};
    end
  end

  // Count consecutive disagreeing cycles; accept the new level on the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      clean <= 1'b0;
    end else if (s == clean) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
      clean <= s;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/sw_gates_debounced.sv
// Debounced N-switch gates block: per-bit synchronise + debounce, then registered
// AND/OR/XOR reductions of the clean vector and one-cycle rise/fall pulses.
// Optional macro GATES_INVERT_EN adds registered y_nand / y_nor / y_xnor outputs.
module sw_gates_debounced
  import gates_pkg::*;
#(
  parameter int N_SW            = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] SW,
  output logic [N_SW-1:0] sw_clean,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic            y_and,
  output logic            y_or,
  output logic            y_xor
`ifdef GATES_INVERT_EN
  ,
  output logic            y_nand,
  output logic            y_nor,
  output logic            y_xnor
`endif
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

  logic [N_SW-1:0] clean_d1;

  for (genvar i = 0; i < N_SW; i++) begin : g_bit
    sw_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .sw    (SW[i]),
      .clean (sw_clean[i])
    );
  end

  // Edge pulses compare the clean vector against its one-cycle-old copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clean_d1 <= '0;
      sw_rise  <= '0;
      sw_fall  <= '0;
    end else begin
      clean_d1 <= sw_clean;
      sw_rise  <= sw_clean & ~clean_d1;
      sw_fall  <= ~sw_clean & clean_d1;
    end
  end

  // Reductions are taken from the whole clean vector at once, so simultaneous
  // acceptances on several bits never expose an intermediate value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_and <= 1'b0;
      y_or  <= 1'b0;
      y_xor <= 1'b0;
    end else begin
      y_and <= &sw_clean;
      y_or  <= |sw_clean;
      y_xor <= ^sw_clean;
    end
  end

`ifdef GATES_INVERT_EN
  // Inverted reductions, registered alongside y_*; reset to the inverse of their reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_nand <= 1'b1;
      y_nor  <= 1'b1;
      y_xnor <= 1'b1;
    end else begin
      y_nand <= ~(&sw_clean);
      y_nor  <= ~(|sw_clean);
      y_xnor <= ~(^sw_clean);
    end
  end
`endif

endmodule

// File: tb/tb_sw_gates_debounced.sv
// Bench for sw_gates_debounced with N_SW=2, DEBOUNCE_CYCLES=4, 10 ns clock.
// Output word layout: {sw_clean[1:0], sw_rise[1:0], sw_fall[1:0], y_and, y_or, y_xor}.
module tb_sw_gates_debounced;

  localparam int N_SW = 2;
  localparam int DEB  = 4;

  typedef struct {
    logic [1:0] sw;
    logic [8:0] exp;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] SW;
  logic [1:0] sw_clean, sw_rise, sw_fall;
  logic       y_and, y_or, y_xor;
`ifdef GATES_INVERT_EN
  logic       y_nand, y_nor, y_xnor;
`endif

  logic [8:0] act;
  assign act = {sw_clean, sw_rise, sw_fall, y_and, y_or, y_xor};

  logic [8:0] exp_q[$];
  vec_t       vecs[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  sw_gates_debounced #(
    .N_SW            (N_SW),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SW       (SW),
    .sw_clean (sw_clean),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .y_and    (y_and),
    .y_or     (y_or),
    .y_xor    (y_xor)
`ifdef GATES_INVERT_EN
    ,
    .y_nand   (y_nand),
    .y_nor    (y_nor),
    .y_xnor   (y_xnor)
`endif
  );

  // Clock and overall time bound
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete within 50000 ns");
    $fatal(1, "timeout");
  end

  function automatic logic [8:0] pk(input logic [1:0] clean, input logic [1:0] rise,
                                    input logic [1:0] fall, input logic [2:0] y);
    return {clean, rise, fall, y};
  endfunction

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (clean,rise,fall,and,or,xor)", name, act, exp);
    end
`ifdef GATES_INVERT_EN
    n_checks++;
    if ({y_nand, y_nor, y_xnor} !== ~exp[2:0]) begin
      n_fail++;
      $display("FAIL %s_inv: got nand/nor/xnor %b expected %b", name,
               {y_nand, y_nor, y_xnor}, ~exp[2:0]);
    end
`endif
  endtask

  task automatic add_rows(input int n, input logic [1:0] sw, input logic [8:0] exp);
    vec_t v;
    v.sw  = sw;
    v.exp = exp;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  initial begin
    // Cycle-by-cycle table: drive SW, take one edge, compare all outputs
    // Clean 00 -> SW=01: accepted on edge 6, pulse and reductions on edge 7
    add_rows(5, 2'b01, pk(2'b00, 2'b00, 2'b00, 3'b000));
    add_rows(1, 2'b01, pk(2'b01, 2'b00, 2'b00, 3'b000));
    add_rows(1, 2'b01, pk(2'b01, 2'b01, 2'b00, 3'b011));
    add_rows(1, 2'b01, pk(2'b01, 2'b00, 2'b00, 3'b011));
    // Glitch: SW[1] high for 3 cycles only, never accepted
    add_rows(3, 2'b11, pk(2'b01, 2'b00, 2'b00, 3'b011));
    add_rows(4, 2'b01, pk(2'b01, 2'b00, 2'b00, 3'b011));
    // Back to 00: fall pulse on bit 0
    add_rows(5, 2'b00, pk(2'b01, 2'b00, 2'b00, 3'b011));
    add_rows(1, 2'b00, pk(2'b00, 2'b00, 2'b00, 3'b011));
    add_rows(1, 2'b00, pk(2'b00, 2'b00, 2'b01, 3'b000));
    add_rows(1, 2'b00, pk(2'b00, 2'b00, 2'b00, 3'b000));
    // 00 -> 11 in one cycle: both rise together, xor never shows 1
    add_rows(5, 2'b11, pk(2'b00, 2'b00, 2'b00, 3'b000));
    add_rows(1, 2'b11, pk(2'b11, 2'b00, 2'b00, 3'b000));
    add_rows(1, 2'b11, pk(2'b11, 2'b11, 2'b00, 3'b110));
    add_rows(1, 2'b11, pk(2'b11, 2'b00, 2'b00, 3'b110));

    // Reset with SW=11: everything cleared during reset and on first edge after
    SW    = 2'b11;
    rst_n = 1'b0;
    #1;
    check("reset_async", 9'b0);
    step();
    step();
    check("reset_held", 9'b0);
    rst_n = 1'b1;
    step();
    check("first_edge", 9'b0);
    SW = 2'b00;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("settle%0d", k), 9'b0);
    end

    // Table-driven section, expectations queued then consumed per edge
    for (int i = 0; i < vecs.size(); i++) begin
      exp_q.push_back(vecs[i].exp);
      SW = vecs[i].sw;
      step();
      check($sformatf("row%0d", i), exp_q.pop_front());
    end

    // Bit 0 falls while bit 1 stays clean high
    SW = 2'b10;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k <= 5)      check($sformatf("fall_b0_%0d", k), pk(2'b11, 2'b00, 2'b00, 3'b110));
      else if (k == 6) check("fall_b0_6", pk(2'b10, 2'b00, 2'b00, 3'b110));
      else if (k == 7) check("fall_b0_7", pk(2'b10, 2'b00, 2'b01, 3'b011));
      else             check("fall_b0_8", pk(2'b10, 2'b00, 2'b00, 3'b011));
    end

    // Bit 0 rises, reset hits at count 2: all progress and state discarded
    SW = 2'b11;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("pre_rst_%0d", k), pk(2'b10, 2'b00, 2'b00, 3'b011));
    end
    rst_n = 1'b0;
    #1;
    check("mid_count_reset", 9'b0);
    step();
    check("mid_count_reset_held", 9'b0);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k <= 5)      check($sformatf("post_rst_%0d", k), 9'b0);
      else if (k == 6) check("post_rst_6", pk(2'b11, 2'b00, 2'b00, 3'b000));
      else if (k == 7) check("post_rst_7", pk(2'b11, 2'b11, 2'b00, 3'b110));
      else             check("post_rst_8", pk(2'b11, 2'b00, 2'b00, 3'b110));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
